// File: rtl/bvend_pkg.sv
// rtl/bvend_pkg.sv - shared definitions for the bvend_change vending controller
// Purpose : FSM state encoding, coin-code constants and coin-value width.
// Contents: ST_* state constants plus state_e enum, COIN_* codes, COIN_VAL_W.
package bvend_pkg;

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_VEND    = 2'd1;
   localparam logic [1:0] ST_CHANGE  = 2'd2;

   typedef enum logic [1:0] {
      E_COLLECT = ST_COLLECT,
      E_VEND    = ST_VEND,
      E_CHANGE  = ST_CHANGE
   } state_e;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_50C  = 2'b01;
   localparam logic [1:0] COIN_1E   = 2'b10;
   localparam logic [1:0] COIN_2E   = 2'b11;

   // Largest coin is 4 units, so three bits hold any decoded value.
   localparam int COIN_VAL_W = 3;

endpackage

// File: rtl/bvend_coin_val.sv
// rtl/bvend_coin_val.sv - combinational coin-code decoder
// Purpose : map a 2-bit coin code to its value in 50-cent units and flag codes
//           the machine is configured not to accept.
// Ports   : i_coin   - coin code (00 none, 01 50c, 10 1 EUR, 11 2 EUR)
//           o_value  - value in 50-cent units (0 when none or rejected)
//           o_reject - coin present but not acceptable by configuration
module bvend_coin_val
   import bvend_pkg::*;
#(
   parameter int ACCEPT_2E = 1
) (
   input  logic [1:0]            i_coin,
   output logic [COIN_VAL_W-1:0] o_value,
   output logic                  o_reject
);

   always_comb begin
      o_value  = '0;
      o_reject = 1'b0;
      case (i_coin)
         COIN_50C: o_value = 3'd1;
         COIN_1E:  o_value = 3'd2;
         COIN_2E: begin
            if (ACCEPT_2E != 0) o_value  = 3'd4;
            else                o_reject = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/bvend_change.sv
// rtl/bvend_change.sv - drink vending controller with credit and change return
// Purpose : collect coins, dispense once PRICE is reached, return leftover
//           credit one 50-cent unit per cycle.
// Ports   : clk          - clock, rising edge
//           rst_n        - synchronous active-low reset
//           coin         - coin code sampled every edge
//           cancel       - refund request (honoured only while collecting)
//           take         - customer removed the drink
//           dispense     - high while a drink is ready
//           change_pulse - one 50-cent unit returned per high cycle
//           coin_reject  - one-cycle pulse after a refused coin
//           credit       - current credit in 50-cent units
module bvend_change
   import bvend_pkg::*;
#(
   parameter int PRICE     = 3,
   parameter int CREDIT_W  = 4,
   parameter int ACCEPT_2E = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          coin,
   input  logic                cancel,
   input  logic                take,
   output logic                dispense,
   output logic                change_pulse,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit
);

   // Credit tops out at PRICE+3 (PRICE-1 held plus a 4-unit coin), so the
   // register must hold that value without wrapping.
   if (PRICE < 1 || PRICE + 3 > (1 << CREDIT_W) - 1) begin : g_bad_params
      $error("bvend_change: PRICE must be >= 1 and PRICE+3 must fit in CREDIT_W bits");
   end

   localparam int SUM_W = CREDIT_W + 1;
   localparam logic [SUM_W-1:0] W_PRICE = SUM_W'(PRICE);

   logic [1:0]            r_state;
   logic [CREDIT_W-1:0]   r_credit;
   logic                  r_reject;

   logic [COIN_VAL_W-1:0] w_value;
   logic                  w_coin_rej;
   logic                  w_coin_seen;
   logic [SUM_W-1:0]      w_sum;
   logic [1:0]            w_state_nxt;
   logic [CREDIT_W-1:0]   w_credit_nxt;
   logic                  w_reject_nxt;

   bvend_coin_val #(
      .ACCEPT_2E (ACCEPT_2E)
   ) u_coin_val (
      .i_coin   (coin),
      .o_value  (w_value),
      .o_reject (w_coin_rej)
   );

   assign w_coin_seen = (coin != COIN_NONE);
   assign w_sum       = {1'b0, r_credit} + SUM_W'(w_value);

   always_comb begin
      w_state_nxt  = r_state;
      w_credit_nxt = r_credit;
      w_reject_nxt = 1'b0;
      case (r_state)
         ST_COLLECT: begin
            if (cancel) begin
               // Cancel wins over a simultaneous coin: the coin is refused.
               w_reject_nxt = w_coin_seen;
               if (r_credit != '0) w_state_nxt = ST_CHANGE;
            end else if (w_coin_rej) begin
               w_reject_nxt = 1'b1;
            end else if (w_sum >= W_PRICE) begin
               w_state_nxt  = ST_VEND;
               w_credit_nxt = CREDIT_W'(w_sum - W_PRICE);
            end else begin
               w_credit_nxt = CREDIT_W'(w_sum);
            end
         end
         ST_VEND: begin
            w_reject_nxt = w_coin_seen;
            if (take) w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_COLLECT;
         end
         ST_CHANGE: begin
            w_reject_nxt = w_coin_seen;
            // Leave on the 1 -> 0 step; the <= guard also recovers from 0.
            if (r_credit <= CREDIT_W'(1)) begin
               w_state_nxt  = ST_COLLECT;
               w_credit_nxt = '0;
            end else begin
               w_credit_nxt = r_credit - CREDIT_W'(1);
            end
         end
         default: begin
            w_state_nxt  = ST_COLLECT;
            w_credit_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= ST_COLLECT;
         r_credit <= '0;
         r_reject <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_credit <= w_credit_nxt;
         r_reject <= w_reject_nxt;
      end
   end

   assign dispense     = (r_state == ST_VEND);
   assign change_pulse = (r_state == ST_CHANGE);
   assign coin_reject  = r_reject;
   assign credit       = r_credit;

endmodule

// File: tb/tb_bvend_change.sv
// tb/tb_bvend_change.sv - self-checking bench for bvend_change
module tb_bvend_change;

   localparam int PRICE = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       cancel = 1'b0;
   logic       take = 1'b0;

   logic       disp_a, chg_a, rej_a;
   logic [3:0] cred_a;
   logic       disp_b, chg_b, rej_b;
   logic [3:0] cred_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: [0] accepts 2 EUR, [1] refuses it.
   int m_credit [2];
   bit m_vend   [2];
   bit m_refund [2];
   bit m_rej    [2];

   always #5 clk = ~clk;

   bvend_change #(.PRICE(3), .CREDIT_W(4), .ACCEPT_2E(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .take(take),
      .dispense(disp_a), .change_pulse(chg_a), .coin_reject(rej_a), .credit(cred_a)
   );

   bvend_change #(.PRICE(3), .CREDIT_W(4), .ACCEPT_2E(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .coin(coin), .cancel(cancel), .take(take),
      .dispense(disp_b), .change_pulse(chg_b), .coin_reject(rej_b), .credit(cred_b)
   );

   // Behavioural rules: a customer either is paying, has a drink waiting,
   // or is being refunded; refused coins raise a flag seen next cycle.
   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         int val;
         val = (coin == 2'd1) ? 1 : (coin == 2'd2) ? 2 : (coin == 2'd3) ? ((d == 0) ? 4 : -1) : 0;
         if (!rst_n) begin
            m_credit[d] = 0; m_vend[d] = 0; m_refund[d] = 0; m_rej[d] = 0;
         end else begin
            m_rej[d] = 0;
            if (m_refund[d]) begin
               if (coin != 0) m_rej[d] = 1;
               m_credit[d] = m_credit[d] - 1;
               if (m_credit[d] == 0) m_refund[d] = 0;
            end else if (m_vend[d]) begin
               if (coin != 0) m_rej[d] = 1;
               if (take) begin
                  m_vend[d]   = 0;
                  m_refund[d] = (m_credit[d] > 0);
               end
            end else if (cancel) begin
               if (coin != 0) m_rej[d] = 1;
               if (m_credit[d] > 0) m_refund[d] = 1;
            end else if (val < 0) begin
               m_rej[d] = 1;
            end else begin
               m_credit[d] = m_credit[d] + val;
               if (m_credit[d] >= PRICE) begin
                  m_credit[d] = m_credit[d] - PRICE;
                  m_vend[d]   = 1;
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic [1:0] c, input logic cn, input logic tk);
      coin = c; cancel = cn; take = tk;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(2'b10, 1'b0, 1'b0);
      drive(2'b10, 1'b0, 1'b0);
      n_tests++;
      if (cred_a !== 4'd0 || disp_a !== 1'b0 || chg_a !== 1'b0 || rej_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state got credit=%0d disp=%b chg=%b rej=%b want 0 0 0 0", cred_a, disp_a, chg_a, rej_a);
      end
      rst_n = 1'b1;
      drive(2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_exact_price();
      drive(2'b01, 1'b0, 1'b0);
      n_tests++;
      if (cred_a !== 4'd1) begin n_fail++; $display("FAIL exact_credit1 got %0d want 1", cred_a); end
      drive(2'b01, 1'b0, 1'b0);
      n_tests++;
      if (cred_a !== 4'd2) begin n_fail++; $display("FAIL exact_credit2 got %0d want 2", cred_a); end
      drive(2'b01, 1'b0, 1'b0);
      n_tests++;
      if (disp_a !== 1'b1 || cred_a !== 4'd0) begin
         n_fail++; $display("FAIL exact_vend got disp=%b credit=%0d want 1 0", disp_a, cred_a);
      end
      drive(2'b00, 1'b0, 1'b1);
      n_tests++;
      if (disp_a !== 1'b0 || chg_a !== 1'b0 || cred_a !== 4'd0) begin
         n_fail++; $display("FAIL exact_take got disp=%b chg=%b credit=%0d want 0 0 0", disp_a, chg_a, cred_a);
      end
      drive(2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_overpay_change();
      int pulses;
      drive(2'b10, 1'b0, 1'b0);
      n_tests++;
      if (cred_a !== 4'd2) begin n_fail++; $display("FAIL over_credit got %0d want 2", cred_a); end
      drive(2'b11, 1'b0, 1'b0);
      n_tests++;
      if (disp_a !== 1'b1 || cred_a !== 4'd3) begin
         n_fail++; $display("FAIL over_vend got disp=%b credit=%0d want 1 3", disp_a, cred_a);
      end
      drive(2'b00, 1'b0, 1'b1);
      take = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10 && chg_a === 1'b1; i++) begin
         pulses++;
         tick();
      end
      n_tests++;
      if (pulses != 3 || cred_a !== 4'd0 || disp_a !== 1'b0 || chg_a !== 1'b0) begin
         n_fail++; $display("FAIL over_pulses got pulses=%0d credit=%0d want 3 0", pulses, cred_a);
      end
   endtask

   task automatic test_cancel();
      int pulses;
      drive(2'b10, 1'b0, 1'b0);
      drive(2'b00, 1'b1, 1'b0);
      cancel = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10 && chg_a === 1'b1; i++) begin
         pulses++;
         tick();
      end
      n_tests++;
      if (pulses != 2 || cred_a !== 4'd0) begin
         n_fail++; $display("FAIL cancel_pulses got pulses=%0d credit=%0d want 2 0", pulses, cred_a);
      end
      drive(2'b01, 1'b0, 1'b0);
      drive(2'b10, 1'b1, 1'b0);
      n_tests++;
      if (rej_a !== 1'b1 || chg_a !== 1'b1 || cred_a !== 4'd1) begin
         n_fail++; $display("FAIL cancel_coin got rej=%b chg=%b credit=%0d want 1 1 1", rej_a, chg_a, cred_a);
      end
      coin = 2'b00; cancel = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10 && chg_a === 1'b1; i++) begin
         pulses++;
         tick();
      end
      n_tests++;
      if (pulses != 1 || rej_a !== 1'b0 || cred_a !== 4'd0) begin
         n_fail++; $display("FAIL cancel_coin_pulses got pulses=%0d rej=%b credit=%0d want 1 0 0", pulses, rej_a, cred_a);
      end
   endtask

   task automatic test_reject();
      drive(2'b10, 1'b0, 1'b0);
      drive(2'b01, 1'b0, 1'b0);
      drive(2'b01, 1'b0, 1'b0);
      n_tests++;
      if (rej_a !== 1'b1 || cred_a !== 4'd0 || disp_a !== 1'b1) begin
         n_fail++; $display("FAIL vend_reject got rej=%b credit=%0d disp=%b want 1 0 1", rej_a, cred_a, disp_a);
      end
      drive(2'b00, 1'b0, 1'b0);
      n_tests++;
      if (rej_a !== 1'b0) begin n_fail++; $display("FAIL vend_reject_width got %b want 0", rej_a); end
      drive(2'b00, 1'b0, 1'b1);
      take = 1'b0;
      rst_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0);
      rst_n = 1'b1;
      drive(2'b01, 1'b0, 1'b0);
      drive(2'b11, 1'b0, 1'b0);
      n_tests++;
      if (rej_b !== 1'b1 || cred_b !== 4'd1 || disp_b !== 1'b0) begin
         n_fail++; $display("FAIL no2e_reject got rej=%b credit=%0d disp=%b want 1 1 0", rej_b, cred_b, disp_b);
      end
      drive(2'b00, 1'b0, 1'b0);
      n_tests++;
      if (rej_b !== 1'b0 || cred_b !== 4'd1) begin
         n_fail++; $display("FAIL no2e_after got rej=%b credit=%0d want 0 1", rej_b, cred_b);
      end
   endtask

   task automatic test_reset_mid_change();
      int pulses;
      rst_n = 1'b0;
      drive(2'b00, 1'b0, 1'b0);
      rst_n = 1'b1;
      drive(2'b10, 1'b0, 1'b0);
      drive(2'b11, 1'b0, 1'b0);
      drive(2'b00, 1'b0, 1'b1);
      take = 1'b0;
      tick();
      n_tests++;
      if (chg_a !== 1'b1 || cred_a !== 4'd2) begin
         n_fail++; $display("FAIL midchg_setup got chg=%b credit=%0d want 1 2", chg_a, cred_a);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_tests++;
      if (chg_a !== 1'b0 || cred_a !== 4'd0 || disp_a !== 1'b0) begin
         n_fail++; $display("FAIL midchg_reset got chg=%b credit=%0d disp=%b want 0 0 0", chg_a, cred_a, disp_a);
      end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (chg_a === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 0) begin n_fail++; $display("FAIL midchg_no_pulse got %0d want 0", pulses); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n  = ($urandom_range(0, 63) != 0);
         coin   = 2'($urandom_range(0, 3));
         cancel = ($urandom_range(0, 7) == 0);
         take   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 0) coin = 2'b00;
         tick();
         n_tests++;
         if (cred_a !== 4'(m_credit[0]) || disp_a !== m_vend[0] || chg_a !== m_refund[0] || rej_a !== m_rej[0]) begin
            n_fail++;
            $display("FAIL rand_a cyc=%0d got c=%0d d=%b p=%b r=%b want c=%0d d=%b p=%b r=%b", i,
                     cred_a, disp_a, chg_a, rej_a, m_credit[0], m_vend[0], m_refund[0], m_rej[0]);
         end
         n_tests++;
         if (cred_b !== 4'(m_credit[1]) || disp_b !== m_vend[1] || chg_b !== m_refund[1] || rej_b !== m_rej[1]) begin
            n_fail++;
            $display("FAIL rand_b cyc=%0d got c=%0d d=%b p=%b r=%b want c=%0d d=%b p=%b r=%b", i,
                     cred_b, disp_b, chg_b, rej_b, m_credit[1], m_vend[1], m_refund[1], m_rej[1]);
         end
      end
      rst_n = 1'b1; coin = 2'b00; cancel = 1'b0; take = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         m_credit[d] = 0; m_vend[d] = 0; m_refund[d] = 0; m_rej[d] = 0;
      end
      test_reset();
      test_exact_price();
      test_overpay_change();
      test_cancel();
      test_reject();
      test_reset_mid_change();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bvend_change.md
BVEND_CHANGE -- requirements
Module: bvend_change

Interface
REQ-001 Parameters SHALL be:
- PRICE, default 3, drink price in 50-cent units (3 = 1.50 EUR).
- CREDIT_W, default 4, credit register width.
- ACCEPT_2E, default 1, 1 = accept 2 EUR coins, 0 = reject them.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates occur on the rising edge.
- rst_n, in, 1, reset, synchronous and active-low.
- coin, in, 2, coin code: 00 none, 01 50 c, 10 1 EUR, 11 2 EUR; sampled every edge.
- cancel, in, 1, refund request.
- take, in, 1, customer has removed the drink.
- dispense, out, 1, drink ready; level output.
- change_pulse, out, 1, one 50-cent unit returned per asserted cycle.
- coin_reject, out, 1, one-cycle pulse: the coin sampled at the previous edge was not accepted.
- credit, out, CREDIT_W, current credit in 50-cent units.

Function
REQ-003 The FSM SHALL have three states: COLLECT, VEND, CHANGE.
REQ-004 Coin values SHALL be 01 -> 1, 10 -> 2, 11 -> 4 units; 00 adds nothing and is never rejected.
REQ-005 In COLLECT, an accepted coin sampled at edge N SHALL give new = credit + value at edge N.
- If new >= PRICE: state becomes VEND and credit becomes new - PRICE at edge N.
- Otherwise: credit becomes new and the state stays COLLECT.
- Result: dispense is high in the cycle after the completing coin (1-cycle latency).
REQ-006 In COLLECT, cancel=1 with credit>0 SHALL move the state to CHANGE with credit unchanged; cancel with credit=0 SHALL be ignored.
REQ-007 In COLLECT, coin!=00 together with cancel=1 SHALL resolve cancel first: the coin is rejected, credit is not increased, and the refund proceeds per REQ-006.
REQ-008 A coin code 11 with ACCEPT_2E=0 SHALL be rejected in every state.
REQ-009 Any nonzero coin sampled in VEND or CHANGE SHALL be rejected, with credit unchanged.
REQ-010 coin_reject SHALL be a registered pulse, high exactly one cycle after each rejected coin edge.
REQ-011 dispense SHALL be 1 exactly while the state is VEND (Moore output).
REQ-012 In VEND, take=1 SHALL move the state to CHANGE if credit>0, else to COLLECT; cancel SHALL be ignored in VEND.
REQ-013 change_pulse SHALL be 1 exactly while the state is CHANGE.
- Credit decrements by 1 at every edge in CHANGE.
- The state returns to COLLECT at the edge where credit goes 1 -> 0.
- The pulse count therefore equals the credit on entry to CHANGE.
- cancel and take SHALL be ignored in CHANGE.
REQ-014 Credit SHALL never wrap; it is bounded by PRICE+3 by construction.
REQ-015 Elaboration SHALL fail unless PRICE >= 1 and PRICE+3 <= 2^CREDIT_W - 1.

Reset
REQ-016 While rst_n=0 at an edge, the block SHALL load:
- state = COLLECT;
- credit = 0;
- coin_reject = 0;
- hence dispense = 0 and change_pulse = 0.
Inputs are ignored during reset.
REQ-017 Reset asserted mid-VEND or mid-CHANGE SHALL discard the remaining credit; no further change_pulse is issued after reset.

Structure
REQ-018 The shared package bvend_pkg SHALL hold the state enum, the coin-code constants and the coin-value widths.
REQ-019 Coin decoding (code plus ACCEPT_2E -> value and reject flag) SHALL be one combinational sub-module, bvend_coin_val; the FSM and credit register remain in bvend_change.

Verification
REQ-020 The bench SHALL cover, with PRICE=3 and CREDIT_W=4 unless stated:
- V1: rst_n=0 for 2 edges with coin=10 -> credit=0, dispense=0, change_pulse=0, coin_reject=0.
- V2: coin 01,01,01 on consecutive edges -> credit 1, 2; dispense=1 the cycle after the third coin with credit=0; take=1 -> COLLECT, zero change pulses.
- V3: coin 10 then 11 -> credit 2, then VEND with credit 3; take=1 -> exactly 3 change_pulse cycles, then credit=0 and COLLECT.
- V4: coin 10 then cancel -> 2 change_pulse cycles. Separately: credit=1, then coin=10 with cancel=1 in the same cycle -> coin_reject pulse and 1 change_pulse.
- V5: coin 01 while in VEND -> coin_reject=1 for one cycle, credit unchanged. ACCEPT_2E=0 with coin 11 in COLLECT -> reject, credit unchanged.
- V6: rst_n=0 during the 2nd cycle of a 3-unit CHANGE -> credit=0, no further change_pulse, state COLLECT.
